// File: rtl/morse_tx.sv
`default_nettype none
// ============================================================================
//  Module   : morse_tx
//  Purpose  : Pops ASCII characters from a show-ahead byte FIFO, converts
//             letters (case-insensitive) and digits to ITU Morse, and keys a
//             single on/off line with standard unit timing. A space byte
//             produces an extra 4-unit gap; any other byte is dropped.
//  Ports    : i_clk    - system clock
//             i_reset  - synchronous, active-low reset
//             i_empty  - FIFO empty flag
//             i_rdata  - FIFO head word (valid while i_empty=0)
//             o_rd     - FIFO pop strobe, one cycle per character
//             o_morse  - registered key line, 1 = mark
//             o_busy   - high while a character is decoded or sent
//  Revision : 1.0 - initial release
// ============================================================================
module morse_tx #(
   parameter int WORD_BITS     = 8,
   parameter int CLKS_PER_UNIT = 6000000
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_empty,
   input  logic [WORD_BITS-1:0] i_rdata,
   output logic                 o_rd,
   output logic                 o_morse,
   output logic                 o_busy
);

   localparam int c_CW = $clog2(4*CLKS_PER_UNIT+1);
   localparam logic [c_CW-1:0] c_T1 = c_CW'(CLKS_PER_UNIT-1);
   localparam logic [c_CW-1:0] c_T3 = c_CW'(3*CLKS_PER_UNIT-1);
   localparam logic [c_CW-1:0] c_T4 = c_CW'(4*CLKS_PER_UNIT-1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DECODE   = 3'd1,
      ST_MARK     = 3'd2,
      ST_SPACE    = 3'd3,
      ST_CHAR_GAP = 3'd4,
      ST_WORD_GAP = 3'd5
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [c_CW-1:0]   r_cnt;
   logic [7:0]        r_char;
   logic [4:0]        r_pat;     // left-aligned, current element in bit 4
   logic [2:0]        r_len;     // elements remaining including current
   logic              r_morse;

   logic [7:0]        w_up;
   logic              w_dec_valid;
   logic [2:0]        w_dec_len;
   logic [4:0]        w_dec_pat;
   logic              w_pop;

   // Only the low byte is decoded; upper bits are intentionally ignored.
   generate
      if (WORD_BITS > 8) begin : g_wide
         logic w_unused_hi;
         assign w_unused_hi = ^i_rdata[WORD_BITS-1:8];
      end
   endgenerate

   assign w_pop   = (r_state == ST_IDLE) && !i_empty && i_reset;
   assign o_rd    = w_pop;
   assign o_morse = r_morse;
   assign o_busy  = (r_state != ST_IDLE);

   // Fold lower case onto upper case before the table lookup.
   assign w_up = (r_char >= 8'h61 && r_char <= 8'h7A) ? (r_char - 8'h20) : r_char;

   // ITU table: {valid, length, pattern left-aligned, 1 = dash}
   always_comb begin
      {w_dec_valid, w_dec_len, w_dec_pat} = 9'd0;
      case (w_up)
         8'h41: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd2, 5'b01000}; // A
         8'h42: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd4, 5'b10000}; // B
         8'h43: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd4, 5'b10100}; // C
         8'h44: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd3, 5'b10000}; // D
         8'h45: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd1, 5'b00000}; // E
         8'h46: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd4, 5'b00100}; // F
         8'h47: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd3, 5'b11000}; // G
         8'h48: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd4, 5'b00000}; // H
         8'h49: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd2, 5'b00000}; // I
         8'h4A: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd4, 5'b01110}; // J
         8'h4B: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd3, 5'b10100}; // K
         8'h4C: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd4, 5'b01000}; // L
         8'h4D: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd2, 5'b11000}; // M
         8'h4E: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd2, 5'b10000}; // N
         8'h4F: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd3, 5'b11100}; // O
         8'h50: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd4, 5'b01100}; // P
         8'h51: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd4, 5'b11010}; // Q
         8'h52: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd3, 5'b01000}; // R
         8'h53: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd3, 5'b00000}; // S
         8'h54: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd1, 5'b10000}; // T
         8'h55: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd3, 5'b00100}; // U
         8'h56: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd4, 5'b00010}; // V
         8'h57: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd3, 5'b01100}; // W
         8'h58: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd4, 5'b10010}; // X
         8'h59: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd4, 5'b10110}; // Y
         8'h5A: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd4, 5'b11000}; // Z
         8'h30: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd5, 5'b11111}; // 0
         8'h31: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd5, 5'b01111}; // 1
         8'h32: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd5, 5'b00111}; // 2
         8'h33: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd5, 5'b00011}; // 3
         8'h34: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd5, 5'b00001}; // 4
         8'h35: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd5, 5'b00000}; // 5
         8'h36: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd5, 5'b10000}; // 6
         8'h37: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd5, 5'b11000}; // 7
         8'h38: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd5, 5'b11100}; // 8
         8'h39: {w_dec_valid, w_dec_len, w_dec_pat} = {1'b1, 3'd5, 5'b11110}; // 9
         default: {w_dec_valid, w_dec_len, w_dec_pat} = 9'd0;
      endcase
   end

   // Next-state logic; every timed state exits on its terminal count.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (!i_empty) w_next = ST_DECODE;
         end
         ST_DECODE: begin
            if (w_dec_valid)          w_next = ST_MARK;
            else if (r_char == 8'h20) w_next = ST_WORD_GAP;
            else                      w_next = ST_IDLE;
         end
         ST_MARK: begin
            if (r_cnt == (r_pat[4] ? c_T3 : c_T1))
               w_next = (r_len > 3'd1) ? ST_SPACE : ST_CHAR_GAP;
         end
         ST_SPACE: begin
            if (r_cnt == c_T1) w_next = ST_MARK;
         end
         ST_CHAR_GAP: begin
            if (r_cnt == c_T3) w_next = ST_IDLE;
         end
         ST_WORD_GAP: begin
            if (r_cnt == c_T4) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state <= ST_IDLE;
         r_morse <= 1'b0;
         r_cnt   <= '0;
         r_char  <= 8'd0;
         r_pat   <= 5'd0;
         r_len   <= 3'd0;
      end else begin
         r_state <= w_next;
         // Registered key line follows the state being entered, so the
         // mark lines up exactly with the MARK state's cycles.
         r_morse <= (w_next == ST_MARK);
         if ((w_next != r_state) || (r_state == ST_IDLE) || (r_state == ST_DECODE))
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + 1'b1;
         if (w_pop)
            r_char <= i_rdata[7:0];
         if ((r_state == ST_DECODE) && w_dec_valid) begin
            r_pat <= w_dec_pat;
            r_len <= w_dec_len;
         end else if ((r_state == ST_SPACE) && (w_next == ST_MARK)) begin
            r_pat <= {r_pat[3:0], 1'b0};
            r_len <= r_len - 3'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_morse_tx.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
//  Module   : tb_morse_tx
//  Purpose  : Directed bench for morse_tx with a show-ahead FIFO model and
//             unit length of 4 clocks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_morse_tx;

   localparam int U = 4;

   logic       clk;
   logic       rst_n;
   logic       empty;
   logic [7:0] rdata;
   logic       rd;
   logic       morse;
   logic       busy;

   int         total;
   int         bad;
   logic       underflow;
   logic [7:0] q[$];
   logic [7:0] popped;

   morse_tx #(
      .WORD_BITS     (8),
      .CLKS_PER_UNIT (U)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .i_empty (empty),
      .i_rdata (rdata),
      .o_rd    (rd),
      .o_morse (morse),
      .o_busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Show-ahead FIFO: pop on the edge, refresh head/empty shortly after.
   initial begin
      underflow = 1'b0;
      empty     = 1'b1;
      rdata     = 8'd0;
      forever begin
         @(posedge clk);
         if (rd === 1'b1) begin
            if (q.size() == 0) underflow = 1'b1;
            else               popped = q.pop_front();
         end
         #2;
         empty = (q.size() == 0);
         rdata = (q.size() != 0) ? q[0] : 8'd0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run(input string tag, input logic val, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check(tag, {31'd0, morse}, {31'd0, val});
      end
   endtask

   task automatic wait_rd(input string tag);
      for (int i = 0; i < 100; i++) begin
         if (rd === 1'b1) break;
         tick();
      end
      check(tag, {31'd0, rd}, 32'd1);
   endtask

   task automatic idle_after(input string tag);
      tick();
      check(tag, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;

      // Reset with FIFO empty
      for (int i = 0; i < 20; i++) begin
         tick();
         check("rst_morse", {31'd0, morse}, 32'd0);
         check("rst_rd",    {31'd0, rd},    32'd0);
         check("rst_busy",  {31'd0, busy},  32'd0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("empty_no_rd", {31'd0, rd}, 32'd0);
      end

      // 'E'
      q.push_back(8'h45);
      wait_rd("E_rd");
      tick();
      check("E_rd_1cyc", {31'd0, rd}, 32'd0);
      check("E_dec_busy", {31'd0, busy}, 32'd1);
      check("E_dec_low", {31'd0, morse}, 32'd0);
      run("E_mark", 1'b1, 4);
      for (int i = 0; i < 12; i++) begin
         tick();
         check("E_gap", {31'd0, morse}, 32'd0);
         check("E_gap_busy", {31'd0, busy}, 32'd1);
      end
      idle_after("E_idle");

      // 'a' then 'A' (case folding)
      q.push_back(8'h61);
      wait_rd("a_rd");
      tick();
      run("a_m1", 1'b1, 4);  run("a_sp", 1'b0, 4);
      run("a_m2", 1'b1, 12); run("a_cg", 1'b0, 12);
      idle_after("a_idle");
      q.push_back(8'h41);
      wait_rd("A_rd");
      tick();
      run("A_m1", 1'b1, 4);  run("A_sp", 1'b0, 4);
      run("A_m2", 1'b1, 12); run("A_cg", 1'b0, 12);
      idle_after("A_idle");

      // "E E": 32 low cycles between marks
      q.push_back(8'h45); q.push_back(8'h20); q.push_back(8'h45);
      wait_rd("EE_rd1");
      tick();
      run("EE_m1", 1'b1, 4);
      run("EE_gap_a", 1'b0, 13);
      check("EE_rd2", {31'd0, rd}, 32'd1);
      run("EE_gap_b", 1'b0, 18);
      check("EE_rd3", {31'd0, rd}, 32'd1);
      run("EE_gap_c", 1'b0, 1);
      run("EE_m2", 1'b1, 4);
      run("EE_cg", 1'b0, 12);
      idle_after("EE_idle");

      // "ET": 14 low cycles, 12-cycle mark
      q.push_back(8'h45); q.push_back(8'h54);
      wait_rd("ET_rd1");
      tick();
      run("ET_m1", 1'b1, 4);
      run("ET_gap_a", 1'b0, 13);
      check("ET_rd2", {31'd0, rd}, 32'd1);
      run("ET_gap_b", 1'b0, 1);
      run("ET_m2", 1'b1, 12);
      run("ET_cg", 1'b0, 12);
      idle_after("ET_idle");

      // '#' dropped, then 'T'
      q.push_back(8'h23); q.push_back(8'h54);
      wait_rd("hash_rd");
      tick();
      check("hash_dec_busy", {31'd0, busy}, 32'd1);
      check("hash_dec_low", {31'd0, morse}, 32'd0);
      tick();
      check("hash_idle_busy", {31'd0, busy}, 32'd0);
      check("hash_T_rd", {31'd0, rd}, 32'd1);
      check("hash_idle_low", {31'd0, morse}, 32'd0);
      tick();
      check("T_dec_low", {31'd0, morse}, 32'd0);
      run("T_mark", 1'b1, 12);
      run("T_cg", 1'b0, 12);
      idle_after("T_idle");

      // 'O' with reset during second dash, then 'E'
      q.push_back(8'h4F); q.push_back(8'h45);
      wait_rd("O_rd");
      tick();
      run("O_m1", 1'b1, 12);
      run("O_sp", 1'b0, 4);
      run("O_m2", 1'b1, 5);
      rst_n = 1'b0;
      tick();
      check("O_rst_morse", {31'd0, morse}, 32'd0);
      check("O_rst_busy", {31'd0, busy}, 32'd0);
      check("O_rst_rd", {31'd0, rd}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("post_rst_rd", {31'd0, rd}, 32'd1);
      tick();
      check("post_dec_low", {31'd0, morse}, 32'd0);
      run("post_E_mark", 1'b1, 4);
      run("post_E_cg", 1'b0, 12);
      idle_after("post_idle");

      check("no_underflow", {31'd0, underflow}, 32'd0);
      check("fifo_drained", q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
